instr_queue: RTL and testbench
==============================

# instr_queue

First-word-fall-through instruction queue between fetch/decode and dispatch. Fetch pushes decoded instruction packets, and dispatch pops them. The head packet is presented with `instr_valid`. Dispatch control asserts `instr_pop` only when every reservation station and the ROB have room. The queue also supplies the `full` backpressure to fetch and the flush path used on branch mispredict.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `WIDTH`, 64: packet width in bits ({pc[31:0], instr[31:0]} by default).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: discard all entries (mispredict/exception redirect).
- `push` input 1: fetch offers `push_data` this cycle.
- `push_data` input WIDTH: packet to enqueue.
- `full` output 1: no free entry; fetch must not expect acceptance.
- `instr_valid` output 1: head entry valid (queue not empty).
- `instr_out` output WIDTH: head packet, combinational from head entry.
- `instr_pop` input 1: dispatch consumes head this cycle.
- `count` output $clog2(DEPTH)+1: occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH×WIDTH register array.
- Pointers: `head` (read) and `tail` (write), each $clog2(DEPTH)+1 bits. The MSB is a wrap bit, and the low bits index the array.
- Pointers increment modulo 2·DEPTH, so the index wraps naturally from DEPTH-1 to 0.
- Empty when `head == tail`. Full when the low bits are equal and the wrap bits differ.
- `count = tail - head`, computed in pointer width (modular subtraction).
- `push_ok = push & !full`. When true, write `push_data` at `tail[low]` and increment `tail`.
- A push while full is dropped silently. Storage and pointers are unchanged.
- `pop_ok = instr_pop & !empty`. When true, increment `head`.
- A pop while empty is ignored, with no pointer movement.
- Push and pop in the same cycle are independent:
  - Not full and not empty: both occur, and `count` is unchanged.
  - Empty: the push is accepted and the pop is ignored, so `count` becomes 1.
  - Full: the push is dropped and the pop is accepted, so `count` becomes DEPTH-1. `full` is evaluated on the pre-edge state, with no same-cycle bypass.
- `flush`: next edge sets `head = tail = 0`. Push and pop in the same cycle are discarded.
- Priority order: `rst` > `flush` > push/pop.
- Array contents are not cleared on flush or reset. Data is don't-care while `instr_valid = 0`.
- `instr_out = mem[head[low]]`, unregistered (fall-through). Valid whenever `instr_valid = 1`.
- `instr_valid = !empty`. `full` and `count` are pure functions of the pointers.

## Timing
- Reset: after a rising edge with `rst = 1`, `head = tail = 0`, so `instr_valid = 0`, `full = 0` and `count = 0`. `instr_out` is undefined.
- Reset mid-operation behaves identically to reset from idle; all queued packets are lost.
- Push latency: a packet pushed at edge N is visible on `instr_out` with `instr_valid = 1` in the cycle after edge N, if the queue was empty. There is no empty-to-output bypass within the same cycle.
- Pop: `instr_pop` sampled at edge N advances the head, and the next packet appears in the cycle after edge N.
- `full` deasserts the cycle after a pop from full.
- `full` asserts the cycle after the DEPTH-th outstanding push.
- Throughput: one push and one pop per cycle sustained. FIFO order is preserved across index wrap-around.
- Flush at edge N: `instr_valid = 0` and `count = 0` from the cycle after N. A push at N+1 is accepted normally.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst` 2 cycles, then no push or pop.
  - Response: `instr_valid = 0`, `full = 0`, `count = 0` every cycle.
- Fill, overflow, drain (DEPTH = 16):
  - Stimulus: push packets 0x00..0x10 (17 pushes), then pop until empty.
  - Response: `full = 1` after the 16th push, and `count = 16`. Packet 0x10 is dropped. Pops return 0x00..0x0F in order, `count` reaches 0 and `instr_valid` drops.
- Simultaneous push and pop:
  - At empty, push A with pop asserted: A accepted, `count = 1`.
  - At count 5, push and pop together for 40 cycles: `count` stays 5 across two index wraps, and output order equals input order.
  - At full, push X with pop: X dropped, `count = 15`, and the head advances.
- Flush:
  - Stimulus: with 7 entries, assert `flush` together with push and pop.
  - Response: next cycle `count = 0` and `instr_valid = 0`. A subsequent push of 0xAB appears on `instr_out` one cycle later.
- Pop while empty:
  - Stimulus: assert `instr_pop` for 3 cycles on an empty queue, then push 0x55.
  - Response: pointers are unchanged during the pops. `instr_out = 0x55` with `count = 1`.
- Reset mid-stream:
  - Stimulus: with 9 entries and a push pending, assert `rst` for one cycle.
  - Response: all outputs are at reset values the next cycle. Old packets never reappear after new pushes.

Source files
------------

// File: rtl/instr_queue.sv
// First-word-fall-through instruction queue between fetch/decode and dispatch.
// Wrap-bit pointers distinguish full from empty; the head entry is read combinationally.
module instr_queue #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   output logic                       full,
   output logic                       instr_valid,
   output logic [WIDTH-1:0]           instr_out,
   input  logic                       instr_pop,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic             empty;
   logic             push_ok;
   logic             pop_ok;

   assign empty       = (head_q == tail_q);
   assign full        = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
   assign count       = tail_q - head_q;
   assign instr_valid = !empty;
   assign instr_out   = mem_q[head_q[AW-1:0]];

   // Full/empty come from the pre-edge pointers, so a pop from full never frees room for a same-cycle push.
   assign push_ok = push && !full;
   assign pop_ok  = instr_pop && !empty;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (push_ok) tail_d = tail_q + PW'(1);
         if (pop_ok)  head_d = head_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Storage is never cleared; entries outside head..tail are don't-care.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push_ok) begin
         mem_q[tail_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_instr_queue;

   localparam int DEPTH = 16;
   localparam int WIDTH = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             push = 1'b0;
   logic [WIDTH-1:0] push_data = '0;
   logic             full;
   logic             instr_valid;
   logic [WIDTH-1:0] instr_out;
   logic             instr_pop = 1'b0;
   logic [$clog2(DEPTH):0] count;

   instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .push        (push),
      .push_data   (push_data),
      .full        (full),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .instr_pop   (instr_pop),
      .count       (count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] mq [$];

   typedef struct {
      bit          r, f, p, po;
      logic [63:0] d;
      bit          e_valid, e_full;
      int          e_count;
      logic [63:0] e_out;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle, advance the model across the edge, settle before checking.
   task automatic step(input bit r, input bit f, input bit p, input bit po, input logic [63:0] d);
      bit pop_ok, push_ok;
      rst = r; flush = f; push = p; instr_pop = po; push_data = d;
      @(posedge clk);
      if (r || f) begin
         mq.delete();
      end else begin
         pop_ok  = po && (mq.size() > 0);
         push_ok = p && (mq.size() < DEPTH);
         if (pop_ok)  void'(mq.pop_front());
         if (push_ok) mq.push_back(d);
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 64'(instr_valid), 64'(mq.size() != 0));
      chk({tag, ".full"},  64'(full),        64'(mq.size() == DEPTH));
      chk({tag, ".count"}, 64'(count),       64'(mq.size()));
      if (mq.size() != 0) chk({tag, ".out"}, instr_out, mq[0]);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0);
   endtask

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{1,0,0,0, 64'h0,  0,0,0, 64'h0};
      tbl[1]  = '{1,0,0,0, 64'h0,  0,0,0, 64'h0};
      tbl[2]  = '{0,0,0,0, 64'h0,  0,0,0, 64'h0};
      tbl[3]  = '{0,0,0,1, 64'h0,  0,0,0, 64'h0};
      tbl[4]  = '{0,0,1,1, 64'h11, 1,0,1, 64'h11};
      tbl[5]  = '{0,0,1,0, 64'h22, 1,0,2, 64'h11};
      tbl[6]  = '{0,0,1,1, 64'h33, 1,0,2, 64'h22};
      tbl[7]  = '{0,0,0,1, 64'h0,  1,0,1, 64'h33};
      tbl[8]  = '{0,1,1,1, 64'h44, 0,0,0, 64'h0};
      tbl[9]  = '{0,0,1,0, 64'hAB, 1,0,1, 64'hAB};
      tbl[10] = '{0,0,0,1, 64'h0,  0,0,0, 64'h0};
      tbl[11] = '{1,0,1,0, 64'h99, 0,0,0, 64'h0};

      // Directed table
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].f, tbl[i].p, tbl[i].po, tbl[i].d);
         chk($sformatf("tbl%0d.valid", i), 64'(instr_valid), 64'(tbl[i].e_valid));
         chk($sformatf("tbl%0d.full", i),  64'(full),        64'(tbl[i].e_full));
         chk($sformatf("tbl%0d.count", i), 64'(count),       64'(tbl[i].e_count));
         if (tbl[i].e_valid) chk($sformatf("tbl%0d.out", i), instr_out, tbl[i].e_out);
      end

      // Reset then idle
      step(1, 0, 0, 0, '0);
      step(1, 0, 0, 0, '0);
      for (int i = 0; i < 4; i++) begin idle(); check_model("idle"); end

      // Fill, overflow, drain
      for (int i = 0; i <= 16; i++) begin
         step(0, 0, 1, 0, 64'(i));
         check_model("fill");
         if (i == 15) begin
            chk("fill.full16", 64'(full), 64'd1);
            chk("fill.count16", 64'(count), 64'd16);
         end
      end
      chk("ovf.count", 64'(count), 64'd16);
      for (int i = 0; i < 16; i++) begin
         chk("drain.out", instr_out, 64'(i));
         step(0, 0, 0, 1, '0);
         check_model("drain");
      end
      chk("drain.valid", 64'(instr_valid), 64'd0);
      chk("drain.count", 64'(count), 64'd0);

      // Push+pop at empty
      step(0, 0, 1, 1, 64'hA);
      chk("pp_empty.count", 64'(count), 64'd1);
      chk("pp_empty.out", instr_out, 64'hA);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 64'h100 + 64'(i));
      chk("pp5.count0", 64'(count), 64'd5);
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 1, 1, 64'h200 + 64'(i));
         check_model("pp5");
         chk("pp5.count", 64'(count), 64'd5);
      end

      // Push+pop at full: push dropped, head advances
      while (mq.size() < DEPTH) step(0, 0, 1, 0, 64'h300 + 64'(mq.size()));
      chk("ppfull.full", 64'(full), 64'd1);
      step(0, 0, 1, 1, 64'hDEAD);
      chk("ppfull.count", 64'(count), 64'd15);
      chk("ppfull.full_after", 64'(full), 64'd0);
      check_model("ppfull");

      // Flush with 7 entries plus concurrent push/pop
      step(1, 0, 0, 0, '0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 64'h400 + 64'(i));
      chk("flush.pre", 64'(count), 64'd7);
      step(0, 1, 1, 1, 64'h777);
      chk("flush.count", 64'(count), 64'd0);
      chk("flush.valid", 64'(instr_valid), 64'd0);
      step(0, 0, 1, 0, 64'hAB);
      chk("flush.out", instr_out, 64'hAB);
      check_model("flush");

      // Pop while empty
      step(0, 0, 0, 1, '0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, '0);
         chk("popempty.count", 64'(count), 64'd0);
      end
      step(0, 0, 1, 0, 64'h55);
      chk("popempty.out", instr_out, 64'h55);
      chk("popempty.count1", 64'(count), 64'd1);

      // Reset mid-stream
      while (mq.size() < 9) step(0, 0, 1, 0, 64'h500 + 64'(mq.size()));
      step(1, 0, 1, 0, 64'h5FF);
      chk("rstmid.count", 64'(count), 64'd0);
      chk("rstmid.valid", 64'(instr_valid), 64'd0);
      chk("rstmid.full", 64'(full), 64'd0);
      step(0, 0, 1, 0, 64'h600);
      step(0, 0, 1, 0, 64'h601);
      chk("rstmid.new0", instr_out, 64'h600);
      step(0, 0, 0, 1, '0);
      chk("rstmid.new1", instr_out, 64'h601);
      check_model("rstmid");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bit r, f, p, po;
         bias = (i / 300) % 3;
         r  = ($urandom_range(0, 199) == 0);
         f  = ($urandom_range(0, 99) == 0);
         p  = ($urandom_range(0, 9) < (bias == 0 ? 8 : bias == 1 ? 3 : 5));
         po = ($urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 8 : 5));
         step(r, f, p, po, {$urandom, $urandom});
         check_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
